// File: rtl/avst_fifo_egress.sv
// Egress stage behind a show-ahead packet FIFO: checks SOP/EOP framing and
// re-times popped words into a 2-entry Avalon-ST output buffer with packet and error counters.
module avst_fifo_egress #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int CNT_WIDTH   = 32,
    localparam int FIFO_WIDTH = DATA_WIDTH + EMPTY_WIDTH + 2
) (
    input  logic                   clock,
    input  logic                   sclr,
    input  logic                   fifo_empty,
    input  logic [FIFO_WIDTH-1:0]  fifo_q,
    output logic                   fifo_rdreq,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_error,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PKT     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic                   error;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [DATA_WIDTH-1:0]  data;
    } entry_t;

    state_t                 state;
    state_t                 state_next;
    entry_t                 slot0;
    entry_t                 slot1;
    entry_t                 in_word;
    logic [1:0]             occ;
    logic                   in_sop;
    logic                   in_eop;
    logic [EMPTY_WIDTH-1:0] in_empty;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   forward;
    logic                   count_pkt;
    logic                   count_err;
    logic                   push;
    logic                   pop;

    assign in_sop   = fifo_q[FIFO_WIDTH-1];
    assign in_eop   = fifo_q[FIFO_WIDTH-2];
    assign in_empty = fifo_q[DATA_WIDTH +: EMPTY_WIDTH];
    assign in_data  = fifo_q[DATA_WIDTH-1:0];

    // The pop decision looks only at registered occupancy, never at out_ready.
    assign fifo_rdreq = !sclr && !fifo_empty && (occ < 2'd2);
    assign out_valid  = (occ != 2'd0);
    assign pop        = out_valid && out_ready;
    assign push       = fifo_rdreq && forward;

    assign out_data  = slot0.data;
    assign out_sop   = slot0.sop;
    assign out_eop   = slot0.eop;
    assign out_empty = slot0.empty;
    assign out_error = slot0.error;

    always_comb begin
        state_next    = state;
        forward       = 1'b0;
        count_pkt     = 1'b0;
        count_err     = 1'b0;
        in_word.sop   = in_sop;
        in_word.eop   = in_eop;
        in_word.error = 1'b0;
        in_word.empty = in_empty;
        in_word.data  = in_data;
        case (state)
            IDLE, DISCARD: begin
                if (in_sop) begin
                    forward = 1'b1;
                    if (in_eop) begin
                        count_pkt  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = PKT;
                    end
                end else begin
                    // Only the first stray word of a fragment counts as an error.
                    count_err  = (state == IDLE);
                    state_next = in_eop ? IDLE : DISCARD;
                end
            end
            PKT: begin
                forward = 1'b1;
                if (!in_sop) begin
                    if (in_eop) begin
                        count_pkt  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    // A new SOP inside a packet closes the old one with a forced error EOP.
                    count_err     = 1'b1;
                    in_word.sop   = 1'b0;
                    in_word.eop   = 1'b1;
                    in_word.empty = '0;
                    in_word.error = 1'b1;
                    state_next    = in_eop ? IDLE : DISCARD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state     <= IDLE;
            pkt_count <= '0;
            err_count <= '0;
        end else if (fifo_rdreq) begin
            state <= state_next;
            if (count_pkt) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (count_err) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end

    // slot0 is always the head; slot1 only holds data when occ is 2.
    always_ff @(posedge clock) begin
        if (sclr) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= in_word;
                    end else begin
                        slot1 <= in_word;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0 <= in_word;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avst_fifo_egress.sv
// Randomized bench for avst_fifo_egress: a queue-based FIFO source, a framing
// reference model and a per-cycle comparison of pops, beats and counters.
module tb_avst_fifo_egress;

    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 32;
    localparam int FW = DW + EW + 2;

    logic          clock = 1'b0;
    logic          sclr;
    logic          fifo_empty;
    logic [FW-1:0] fifo_q;
    logic          fifo_rdreq;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          out_error;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;

    avst_fifo_egress #(
        .DATA_WIDTH (DW),
        .EMPTY_WIDTH(EW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock     (clock),
        .sclr      (sclr),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty),
        .out_error (out_error),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
        logic          err;
    } beat_t;

    logic [FW-1:0] src_q[$];
    beat_t         exp_q[$];
    bit            in_pkt;
    bit            discarding;
    bit            just_reset;
    logic [CW-1:0] m_pkt;
    logic [CW-1:0] m_err;
    int            compared;
    int            mismatched;
    int            gap_pct;
    int            ready_pct;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [FW-1:0] mkWord(input bit s, input bit e, input logic [EW-1:0] emp);
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        return {s, e, emp, d};
    endfunction

    // Framing reference: decide what one popped word becomes on the output.
    task automatic modelPop(input logic [FW-1:0] w);
        beat_t b;
        logic  s;
        logic  e;
        s       = w[FW-1];
        e       = w[FW-2];
        b.data  = w[DW-1:0];
        b.empty = w[DW +: EW];
        b.sop   = s;
        b.eop   = e;
        b.err   = 1'b0;
        if (s && !in_pkt) begin
            exp_q.push_back(b);
            discarding = 1'b0;
            if (e) m_pkt = m_pkt + 1;
            else   in_pkt = 1'b1;
        end else if (s && in_pkt) begin
            b.sop   = 1'b0;
            b.eop   = 1'b1;
            b.empty = '0;
            b.err   = 1'b1;
            exp_q.push_back(b);
            m_err      = m_err + 1;
            in_pkt     = 1'b0;
            discarding = !e;
        end else if (in_pkt) begin
            exp_q.push_back(b);
            if (e) begin
                m_pkt  = m_pkt + 1;
                in_pkt = 1'b0;
            end
        end else begin
            if (!discarding) m_err = m_err + 1;
            discarding = !e;
        end
    endtask

    task automatic applyStimulus(input bit rst);
        bit gap;
        bit exp_rd;
        @(negedge clock);
        sclr       = rst;
        gap        = ($urandom_range(0, 99) < gap_pct);
        fifo_empty = (src_q.size() == 0) || gap;
        fifo_q     = fifo_empty ? '0 : src_q[0];
        out_ready  = ($urandom_range(0, 99) < ready_pct);
        #1;
        exp_rd = !rst && !fifo_empty && (exp_q.size() < 2);
        checkOutput("rdreq", fifo_rdreq, exp_rd);
        checkOutput("valid", out_valid, exp_q.size() > 0);
        checkOutput("pkt_count", pkt_count, m_pkt);
        checkOutput("err_count", err_count, m_err);
        if (exp_q.size() > 0) begin
            checkOutput("data", out_data, exp_q[0].data);
            checkOutput("sop", out_sop, exp_q[0].sop);
            checkOutput("eop", out_eop, exp_q[0].eop);
            checkOutput("empty", out_empty, exp_q[0].empty);
            checkOutput("error", out_error, exp_q[0].err);
        end
        if (just_reset) begin
            checkOutput("rst_data", out_data, 0);
            checkOutput("rst_flags", {out_sop, out_eop, out_error, out_empty}, 0);
        end
        just_reset = rst;
        if (rst) begin
            exp_q.delete();
            in_pkt     = 1'b0;
            discarding = 1'b0;
            m_pkt      = '0;
            m_err      = '0;
        end else begin
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (exp_rd) modelPop(src_q.pop_front());
        end
    endtask

    task automatic drain();
        bit done;
        gap_pct   = 0;
        ready_pct = 100;
        for (int i = 0; i < 500 && (src_q.size() > 0 || exp_q.size() > 0); i++) begin
            applyStimulus(1'b0);
        end
        done = (src_q.size() == 0) && (exp_q.size() == 0);
        checkOutput("drain_done", done, 1);
        applyStimulus(1'b0);
    endtask

    initial begin
        int len;
        bit s;
        bit e;
        sclr       = 1'b1;
        fifo_empty = 1'b1;
        fifo_q     = '0;
        out_ready  = 1'b0;
        in_pkt     = 1'b0;
        discarding = 1'b0;
        m_pkt      = '0;
        m_err      = '0;
        compared   = 0;
        mismatched = 0;
        gap_pct    = 0;
        ready_pct  = 100;
        repeat (2) @(posedge clock);
        just_reset = 1'b1;
        applyStimulus(1'b1);

        // 3-beat packet at full rate
        src_q.push_back(mkWord(1, 0, 3'd0));
        src_q.push_back(mkWord(0, 0, 3'd0));
        src_q.push_back(mkWord(0, 1, 3'd2));
        drain();

        // 8-beat packet with a 5-cycle backpressure window
        for (int i = 0; i < 8; i++) src_q.push_back(mkWord(i == 0, i == 7, EW'(i)));
        repeat (4) applyStimulus(1'b0);
        ready_pct = 0;
        repeat (5) applyStimulus(1'b0);
        drain();

        // stray EOP fragment after reset, then a good single-beat packet
        applyStimulus(1'b1);
        src_q.push_back(mkWord(0, 1, 3'd4));
        src_q.push_back(mkWord(1, 1, 3'd1));
        drain();

        // truncated packet A, aborted B, clean C
        src_q.push_back(mkWord(1, 0, 3'd0));
        src_q.push_back(mkWord(0, 0, 3'd0));
        src_q.push_back(mkWord(1, 0, 3'd6));
        src_q.push_back(mkWord(0, 0, 3'd0));
        src_q.push_back(mkWord(0, 1, 3'd3));
        src_q.push_back(mkWord(1, 0, 3'd0));
        src_q.push_back(mkWord(0, 1, 3'd7));
        drain();

        // reset with a full buffer in mid-packet; leftovers become a fragment
        src_q.push_back(mkWord(1, 0, 3'd0));
        for (int i = 0; i < 4; i++) src_q.push_back(mkWord(0, 0, 3'd0));
        src_q.push_back(mkWord(0, 1, 3'd2));
        ready_pct = 0;
        repeat (4) applyStimulus(1'b0);
        applyStimulus(1'b1);
        drain();

        // back-to-back single-beat packets
        repeat (4) src_q.push_back(mkWord(1, 1, 3'd5));
        drain();

        // random framing with corrupted SOP/EOP, FIFO gaps and backpressure
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                s = (i == 0);
                e = (i == len - 1);
                if ($urandom_range(0, 9) == 0) s = !s;
                if ($urandom_range(0, 9) == 0) e = !e;
                src_q.push_back(mkWord(s, e, EW'($urandom)));
            end
        end
        gap_pct   = 25;
        ready_pct = 60;
        repeat (300) applyStimulus(1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/avst_fifo_egress.md
Name: avst_fifo_egress

Overview:
Egress stage directly downstream of the show-ahead single-clock packet FIFO. It pops words from the FIFO and presents them as an Avalon-ST source with a 2-entry output buffer, so that fifo_rdreq never depends combinationally on out_ready. It checks SOP/EOP framing on every popped word, discards malformed fragments, and keeps packet and error counters for CSR readout.

Parameters:
DATA_WIDTH, 64, payload width per beat
EMPTY_WIDTH, 3, width of the empty-symbols field (log2 of bytes per beat)
CNT_WIDTH, 32, width of the statistics counters
FIFO_WIDTH, DATA_WIDTH+EMPTY_WIDTH+2, derived localparam; FIFO word layout is {sop, eop, empty, data}, MSB first

Ports:
clock  in  1  single clock domain
sclr  in  1  synchronous reset, active-high
fifo_empty  in  1  FIFO empty flag
fifo_q  in  FIFO_WIDTH  show-ahead FIFO head word, valid whenever fifo_empty=0
fifo_rdreq  out  1  pop strobe to FIFO
out_valid  out  1  Avalon-ST valid
out_ready  in  1  Avalon-ST ready, ready latency 0
out_data  out  DATA_WIDTH  beat payload
out_sop  out  1  start of packet
out_eop  out  1  end of packet
out_empty  out  EMPTY_WIDTH  empty symbols, meaningful only when out_eop=1
out_error  out  1  set on a forced-EOP beat that terminates a truncated packet
pkt_count  out  CNT_WIDTH  count of good packets forwarded, wraps
err_count  out  CNT_WIDTH  count of framing-error events, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clock; reset port is sclr.
- Reset (sclr=1 at an edge): occupancy=0, FSM=IDLE, counters=0, out_valid=0, all out_* data/flag fields=0. fifo_rdreq=0 combinationally while sclr=1. Buffered words are lost.
- Pop rule: fifo_rdreq = !sclr && !fifo_empty && (occ<2). occ is the registered count of buffer entries. Every pop consumes fifo_q at that edge.
- Push rule: a popped word is written into the buffer only if the FSM forwards it. Dropped words are popped and discarded.
- Output: out_* presents the buffer head. A pop occurs on out_valid && out_ready. occ_next = occ + push - pop. A push and a pop in the same cycle are legal at any occ.
- Latency: with occ=0, a word popped at edge t is visible on out_* after edge t, with out_valid=1 in cycle t+1.
- Throughput: with out_ready held at 1, the block sustains 1 beat/clock (steady occ=1).
- Ordering: forwarded words keep FIFO order. No duplication. No loss except for words dropped by the FSM.
- FSM states: IDLE (expect SOP), PKT (inside a packet), DISCARD (dropping until the next SOP). The FSM advances only on a pop.
  - IDLE, sop&eop: forward; pkt_count+1; stay in IDLE.
  - IDLE, sop&!eop: forward; go to PKT.
  - IDLE, !sop: drop; err_count+1; go to IDLE if eop, else DISCARD.
  - PKT, !sop&!eop: forward; stay in PKT.
  - PKT, !sop&eop: forward; pkt_count+1; go to IDLE.
  - PKT, sop: framing error. Forward this word with sop forced 0, eop forced 1, empty forced 0, error=1. err_count+1. pkt_count unchanged. Then go to IDLE if the word's own eop=1, else DISCARD.
  - DISCARD, sop: handle exactly as IDLE with sop (no error count).
  - DISCARD, !sop: drop; go to IDLE if eop, else stay in DISCARD. No additional err_count.
- out_error=0 on every beat except the forced-EOP beat.
- Counters update at the pop edge, not at output acceptance. Both counters wrap modulo 2^CNT_WIDTH.
- fifo_empty rising while occ>0: the buffer still drains normally.

Test Plan:
1. 3-beat packet (sop on beat 0, eop on beat 2, empty=2), out_ready=1 -> fifo_rdreq high for 3 consecutive cycles; out_valid high the cycle after the first rdreq for 3 cycles; out_sop/out_eop/out_empty=1/0/0, 0/0/0, 0/1/2; pkt_count=1, err_count=0.
2. 8-beat packet, out_ready=0 for 5 cycles starting after beat 2 is accepted -> rdreq deasserts once occ=2; beats resume in order after out_ready=1; all 8 delivered exactly once; pkt_count=1.
3. After reset, a non-SOP beat with eop=1, then a good 1-beat packet -> first beat dropped, out_valid stays 0 for it; err_count=1; good packet forwarded; pkt_count=1.
4. A0(sop), A1, then B0(sop), B1, B2(eop), then a good packet C -> output A0, A1, then B0 with sop=0/eop=1/error=1/empty=0; B1, B2 dropped; C forwarded intact; err_count=1, pkt_count=1.
5. sclr asserted for 1 cycle with occ=2 mid-packet -> out_valid=0 and counters=0 the next cycle, rdreq=0 during sclr; the next non-SOP word is dropped and err_count=1.
6. Single-beat packet sop=1, eop=1, empty=5, repeated 4 times back-to-back -> 4 output beats on consecutive cycles, each sop=eop=1 with out_empty=5; pkt_count=4.
